// File: rtl/cmac_link_supervisor_if.sv
// Control/status bundle between the CMAC link supervisor and its host logic.
// The slave side belongs to the supervisor; the master side drives enables and link indications.
interface cmac_link_supervisor_if;
    logic        enable;
    logic        clear_counters;
    logic        cmac_aligned_sync;
    logic        gt_locked_sync;
    logic        link_up;
    logic        restart_req;
    logic [15:0] link_down_count;
    logic [15:0] restart_count;
    logic [2:0]  sup_state;

    modport master (
        output enable, clear_counters, cmac_aligned_sync, gt_locked_sync,
        input  link_up, restart_req, link_down_count, restart_count, sup_state
    );

    modport slave (
        input  enable, clear_counters, cmac_aligned_sync, gt_locked_sync,
        output link_up, restart_req, link_down_count, restart_count, sup_state
    );
endinterface

// File: rtl/cmac_link_supervisor.sv
// Debounces CMAC alignment and GT lock into link_up, counts link drops and
// pulses restart_req into the wrapper when alignment does not arrive in time.
module cmac_link_supervisor #(
    parameter int DEBOUNCE_CYCLES      = 1024,
    parameter int TIMEOUT_CYCLES       = 16777216,
    parameter int RESTART_PULSE_CYCLES = 16
) (
    input logic                   s_axi_aclk,
    input logic                   s_axi_sreset,
    cmac_link_supervisor_if.slave sup
);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    // One extra count so link_up rises DEBOUNCE_CYCLES+1 edges after QUALIFY entry.
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PLS_W = (RESTART_PULSE_CYCLES > 1) ? $clog2(RESTART_PULSE_CYCLES) : 1;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES);
    localparam logic [PLS_W-1:0] PLS_LAST = PLS_W'(RESTART_PULSE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_ALIGN = 3'd1,
        QUALIFY    = 3'd2,
        UP         = 3'd3,
        RESTART    = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d, tmo_next;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [PLS_W-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [15:0]      link_down_count_q, link_down_count_d;
    logic [15:0]      restart_count_q, restart_count_d;
    logic             ok;
    logic             drop_evt;
    logic             restart_evt;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [15:0] count_next(input logic [15:0] v, input logic clr,
                                               input logic inc);
        if (clr)
            return 16'd0;
        else if (inc)
            return sat_inc16(v);
        else
            return v;
    endfunction

    assign ok       = sup.cmac_aligned_sync & sup.gt_locked_sync;
    assign tmo_next = (tmo_cnt_q == TMO_LAST) ? '0 : tmo_cnt_q + TMO_W'(1);

    always_comb begin
        state_d     = state_q;
        tmo_cnt_d   = tmo_cnt_q;
        deb_cnt_d   = deb_cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        drop_evt    = 1'b0;
        restart_evt = 1'b0;

        if (!sup.enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = WAIT_ALIGN;
                    tmo_cnt_d = '0;
                end
                WAIT_ALIGN: begin
                    tmo_cnt_d = tmo_next;
                    if (ok) begin
                        state_d   = QUALIFY;
                        deb_cnt_d = '0;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        state_d     = RESTART;
                        pulse_cnt_d = '0;
                        restart_evt = 1'b1;
                    end
                end
                QUALIFY: begin
                    // The timeout keeps running here so a flapping link still gets restarted.
                    tmo_cnt_d = tmo_next;
                    if (!ok) begin
                        state_d = WAIT_ALIGN;
                    end else if (deb_cnt_q == DEB_LAST) begin
                        state_d = UP;
                    end else begin
                        deb_cnt_d = deb_cnt_q + DEB_W'(1);
                        if (tmo_cnt_q == TMO_LAST) begin
                            state_d     = RESTART;
                            pulse_cnt_d = '0;
                            restart_evt = 1'b1;
                        end
                    end
                end
                UP: begin
                    if (!ok) begin
                        state_d   = WAIT_ALIGN;
                        tmo_cnt_d = '0;
                        drop_evt  = 1'b1;
                    end
                end
                RESTART: begin
                    if (pulse_cnt_q == PLS_LAST) begin
                        state_d   = WAIT_ALIGN;
                        tmo_cnt_d = '0;
                    end else begin
                        pulse_cnt_d = pulse_cnt_q + PLS_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        link_down_count_d = count_next(link_down_count_q, sup.clear_counters, drop_evt);
        restart_count_d   = count_next(restart_count_q, sup.clear_counters, restart_evt);
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_sreset) begin
            state_q           <= IDLE;
            tmo_cnt_q         <= '0;
            deb_cnt_q         <= '0;
            pulse_cnt_q       <= '0;
            link_down_count_q <= '0;
            restart_count_q   <= '0;
        end else begin
            state_q           <= state_d;
            tmo_cnt_q         <= tmo_cnt_d;
            deb_cnt_q         <= deb_cnt_d;
            pulse_cnt_q       <= pulse_cnt_d;
            link_down_count_q <= link_down_count_d;
            restart_count_q   <= restart_count_d;
        end
    end

    assign sup.link_up         = (state_q == UP);
    assign sup.restart_req     = (state_q == RESTART);
    assign sup.link_down_count = link_down_count_q;
    assign sup.restart_count   = restart_count_q;
    assign sup.sup_state       = state_q;
endmodule

// File: tb/tb_cmac_link_supervisor.sv
// Directed bench for cmac_link_supervisor with DEBOUNCE=8, TIMEOUT=64, PULSE=4.
// Per-cycle vector table plus a backdoor-preloaded saturation sequence.
module tb_cmac_link_supervisor;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    cmac_link_supervisor_if sup_if ();

    cmac_link_supervisor #(
        .DEBOUNCE_CYCLES      (8),
        .TIMEOUT_CYCLES       (64),
        .RESTART_PULSE_CYCLES (4)
    ) dut (
        .s_axi_aclk   (clk),
        .s_axi_sreset (rst),
        .sup          (sup_if)
    );

    typedef struct {
        logic        rst;
        logic        en;
        logic        clr;
        logic        ok;
        logic        lu;
        logic        rr;
        logic [2:0]  st;
        logic [15:0] ldc;
        logic [15:0] rc;
    } vec_t;

    vec_t vecs[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic void add(input int r, input int en, input int clr, input int ok,
                                input int lu, input int rr, input int st, input int ldc,
                                input int rc, input int n);
        vec_t v;
        v.rst = 1'(r);
        v.en  = 1'(en);
        v.clr = 1'(clr);
        v.ok  = 1'(ok);
        v.lu  = 1'(lu);
        v.rr  = 1'(rr);
        v.st  = 3'(st);
        v.ldc = 16'(ldc);
        v.rc  = 16'(rc);
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d actual=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic en, input logic clr, input logic ok,
                         input logic phase);
        rst                      = r;
        sup_if.enable            = en;
        sup_if.clear_counters    = clr;
        // When ok is low, only one of the two qualifiers drops, alternating by step.
        sup_if.cmac_aligned_sync = ok | phase;
        sup_if.gt_locked_sync    = ok | ~phase;
    endtask

    task automatic wait_up(input string name, input int limit);
        int n;
        n = 0;
        while (!sup_if.link_up && n < limit) begin
            tick();
            n++;
        end
        chk(name, n, 32'(sup_if.link_up), 32'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

        // Reset held with enable and ok high, then qualify.
        add(1, 1, 0, 1, 0, 0, 0, 0, 0, 5);
        add(0, 1, 0, 1, 0, 0, 1, 0, 0, 1);
        add(0, 1, 0, 1, 0, 0, 2, 0, 0, 9);
        add(0, 1, 0, 1, 1, 0, 3, 0, 0, 3);
        // Single-cycle drop, then requalify.
        add(0, 1, 0, 0, 0, 0, 1, 1, 0, 1);
        add(0, 1, 0, 1, 0, 0, 2, 1, 0, 9);
        add(0, 1, 0, 1, 1, 0, 3, 1, 0, 1);
        // Drop coinciding with clear_counters.
        add(0, 1, 1, 0, 0, 0, 1, 0, 0, 1);
        add(0, 1, 0, 1, 0, 0, 2, 0, 0, 9);
        add(0, 1, 0, 1, 1, 0, 3, 0, 0, 1);
        // Debounce glitch after 6 high cycles.
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0, 1, 0, 0, 1);
        add(0, 1, 0, 1, 0, 0, 2, 0, 0, 6);
        add(0, 1, 0, 0, 0, 0, 1, 0, 0, 1);
        add(0, 1, 0, 1, 0, 0, 2, 0, 0, 9);
        add(0, 1, 0, 1, 1, 0, 3, 0, 0, 1);
        // Timeout restart, re-arm, and enable drop in the 2nd pulse cycle.
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0, 1, 0, 0, 64);
        add(0, 1, 0, 0, 0, 1, 4, 0, 1, 4);
        add(0, 1, 0, 0, 0, 0, 1, 0, 1, 64);
        add(0, 1, 0, 0, 0, 1, 4, 0, 2, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 2, 2);
        // Clear alone, then reset in the middle of a restart pulse.
        add(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0, 1, 0, 0, 64);
        add(0, 1, 0, 0, 0, 1, 4, 0, 1, 2);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0, 1, 0, 0, 1);
        // Flapping link: the timer keeps running through QUALIFY and times out.
        for (int k = 1; k <= 63; k++) add(0, 1, 0, k % 2, 0, 0, (k % 2) ? 2 : 1, 0, 0, 1);
        add(0, 1, 0, 1, 0, 1, 4, 0, 1, 1);
        add(0, 0, 0, 1, 0, 0, 0, 0, 1, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].clr, vecs[i].ok, i[0]);
            tick();
            chk("link_up", i, 32'(sup_if.link_up), 32'(vecs[i].lu));
            chk("restart_req", i, 32'(sup_if.restart_req), 32'(vecs[i].rr));
            chk("sup_state", i, 32'(sup_if.sup_state), 32'(vecs[i].st));
            chk("link_down_count", i, 32'(sup_if.link_down_count), 32'(vecs[i].ldc));
            chk("restart_count", i, 32'(sup_if.restart_count), 32'(vecs[i].rc));
        end

        // Saturation of link_down_count from a preloaded 0xFFFE.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_up("sat_first_up", 20);
        force dut.link_down_count_q = 16'hFFFE;
        #1;
        release dut.link_down_count_q;
        chk("sat_preload", 0, 32'(sup_if.link_down_count), 32'h0000FFFE);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk("sat_drop_to_max", 1, 32'(sup_if.link_down_count), 32'h0000FFFF);
        chk("sat_link_fell", 1, 32'(sup_if.link_up), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_up("sat_second_up", 20);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("sat_hold_max", 2, 32'(sup_if.link_down_count), 32'h0000FFFF);
        chk("sat_state", 2, 32'(sup_if.sup_state), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
